// File: rtl/stored_block_packer_if.sv
// Byte-stream handshake between the input FIFO, the stored-block packer and the output FIFO.
// The master side is the packer; the slave side is the surrounding FIFO pair.
interface stored_block_packer_if;
   logic [31:0] din_32;
   logic        din_empty;
   logic        din_rd_en;
   logic [31:0] dout_32;
   logic        dout_valid;
   logic        dout_ready;
   logic        dout_last;
   logic [2:0]  dout_bytes;

   modport master (
      input  din_32, din_empty, dout_ready,
      output din_rd_en, dout_32, dout_valid, dout_last, dout_bytes
   );

   modport slave (
      output din_32, din_empty, dout_ready,
      input  din_rd_en, dout_32, dout_valid, dout_last, dout_bytes
   );
endinterface

// File: rtl/stored_block_packer.sv
// DEFLATE stored-block (BTYPE=00) packer: header word + raw words in, packed byte stream out.
// Define STORED_CRC32_EN to add a running gzip CRC-32 over the raw data bytes.
module stored_block_packer #(
   parameter int unsigned MAX_BLOCK = 65535
) (
   input  logic                  clk,
   input  logic                  rst,
   stored_block_packer_if.master bus,
   output logic                  busy
`ifdef STORED_CRC32_EN
   ,
   output logic [31:0]           crc32_out,
   output logic                  crc32_valid
`endif
);

   typedef enum logic [1:0] {StIdle, StHdr, StData, StFlush} state_e;

   localparam logic [23:0] MaxLen = 24'(MAX_BLOCK);

   state_e      st_q;
   logic        bfinal_q;
   logic [23:0] remaining_q;
   logic [2:0]  hdr_idx_q;
   logic [1:0]  lane_q;
   logic [15:0] seg_pos_q;
   logic [23:0] acc_q;
   logic [1:0]  acc_cnt_q;
   logic [31:0] dout_q;
   logic        dout_valid_q;
   logic        dout_last_q;
   logic [2:0]  dout_bytes_q;

   logic [15:0] seg_len;
   logic        seg_final;
   logic [23:0] rem_after;
   logic        out_free;
   logic        acc_room;
   logic        hdr_done;
   logic        seg_last;
   logic        produce;
   logic        pop;
   logic        stream_end;
   logic [7:0]  byte_val;

   always_comb begin
      seg_len    = (remaining_q > MaxLen) ? MaxLen[15:0] : remaining_q[15:0];
      seg_final  = bfinal_q && (remaining_q <= MaxLen);
      rem_after  = remaining_q - {8'h00, seg_len};
      out_free   = !dout_valid_q || bus.dout_ready;
      // The 4th byte goes straight to the output register, so it alone needs a free slot.
      acc_room   = (acc_cnt_q != 2'd3) || out_free;
      hdr_done   = (hdr_idx_q == 3'd4);
      seg_last   = (seg_pos_q == (seg_len - 16'd1));
      produce    = 1'b0;
      pop        = 1'b0;
      stream_end = 1'b0;
      byte_val   = 8'h00;
      case (st_q)
         StIdle: begin
            pop = !bus.din_empty;
         end
         StHdr: begin
            produce    = acc_room;
            stream_end = hdr_done && (seg_len == 16'd0) && seg_final;
            case (hdr_idx_q)
               3'd0:    byte_val = {7'b0, seg_final};
               3'd1:    byte_val = seg_len[7:0];
               3'd2:    byte_val = seg_len[15:8];
               3'd3:    byte_val = ~seg_len[7:0];
               default: byte_val = ~seg_len[15:8];
            endcase
         end
         StData: begin
            produce    = !bus.din_empty && acc_room;
            byte_val   = bus.din_32[{lane_q, 3'b000} +: 8];
            pop        = produce && ((lane_q == 2'd3) || seg_last);
            stream_end = seg_last && seg_final;
         end
         default: ;
      endcase
   end

   assign bus.din_rd_en  = pop && !rst;
   assign bus.dout_32    = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_last  = dout_last_q;
   assign bus.dout_bytes = dout_bytes_q;
   assign busy           = (st_q != StIdle);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q         <= StIdle;
         bfinal_q     <= 1'b0;
         remaining_q  <= 24'd0;
         hdr_idx_q    <= 3'd0;
         lane_q       <= 2'd0;
         seg_pos_q    <= 16'd0;
         acc_q        <= 24'd0;
         acc_cnt_q    <= 2'd0;
         dout_q       <= 32'd0;
         dout_valid_q <= 1'b0;
         dout_last_q  <= 1'b0;
         dout_bytes_q <= 3'd4;
      end else begin
         if (dout_valid_q && bus.dout_ready) begin
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_bytes_q <= 3'd4;
         end

         if (produce) begin
            if (acc_cnt_q == 2'd3) begin
               // A word that completes the stream carries last itself; FLUSH then has nothing to do.
               dout_q       <= {byte_val, acc_q};
               dout_valid_q <= 1'b1;
               dout_last_q  <= stream_end;
               dout_bytes_q <= 3'd4;
               acc_q        <= 24'd0;
               acc_cnt_q    <= 2'd0;
            end else begin
               case (acc_cnt_q)
                  2'd0:    acc_q[7:0]   <= byte_val;
                  2'd1:    acc_q[15:8]  <= byte_val;
                  default: acc_q[23:16] <= byte_val;
               endcase
               acc_cnt_q <= acc_cnt_q + 2'd1;
            end
         end

         case (st_q)
            StIdle: begin
               if (!bus.din_empty) begin
                  bfinal_q    <= bus.din_32[0];
                  remaining_q <= {bus.din_32[15:8], bus.din_32[23:16], bus.din_32[31:24]};
                  hdr_idx_q   <= 3'd0;
                  st_q        <= StHdr;
               end
            end
            StHdr: begin
               if (produce) begin
                  if (hdr_done) begin
                     hdr_idx_q <= 3'd0;
                     lane_q    <= 2'd0;
                     seg_pos_q <= 16'd0;
                     if (seg_len != 16'd0) begin
                        st_q <= StData;
                     end else if (seg_final) begin
                        st_q <= StFlush;
                     end else begin
                        st_q <= StIdle;
                     end
                  end else begin
                     hdr_idx_q <= hdr_idx_q + 3'd1;
                  end
               end
            end
            StData: begin
               if (produce) begin
                  if (seg_last) begin
                     remaining_q <= rem_after;
                     lane_q      <= 2'd0;
                     seg_pos_q   <= 16'd0;
                     hdr_idx_q   <= 3'd0;
                     if (rem_after != 24'd0) begin
                        st_q <= StHdr;
                     end else if (bfinal_q) begin
                        st_q <= StFlush;
                     end else begin
                        st_q <= StIdle;
                     end
                  end else begin
                     lane_q    <= lane_q + 2'd1;
                     seg_pos_q <= seg_pos_q + 16'd1;
                  end
               end
            end
            StFlush: begin
               if (acc_cnt_q == 2'd0) begin
                  st_q <= StIdle;
               end else if (out_free) begin
                  dout_q       <= {8'h00, acc_q};
                  dout_valid_q <= 1'b1;
                  dout_last_q  <= 1'b1;
                  dout_bytes_q <= {1'b0, acc_cnt_q};
                  acc_q        <= 24'd0;
                  acc_cnt_q    <= 2'd0;
                  st_q         <= StIdle;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

`ifdef STORED_CRC32_EN
   logic [31:0] crc_q;
   logic [31:0] crc_next;

   always_comb begin
      crc_next = crc_q ^ {24'h0, byte_val};
      for (int i = 0; i < 8; i++) begin
         crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB88320) : (crc_next >> 1);
      end
   end

   // No raw byte can be produced while the last word is pending, so re-init never drops one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_q <= 32'hFFFF_FFFF;
      end else if (crc32_valid) begin
         crc_q <= 32'hFFFF_FFFF;
      end else if ((st_q == StData) && produce) begin
         crc_q <= crc_next;
      end
   end

   assign crc32_valid = dout_valid_q && bus.dout_ready && dout_last_q;
   assign crc32_out   = ~crc_q;
`endif

endmodule

// File: tb/tb_stored_block_packer.sv
// Self-checking bench for stored_block_packer: directed and randomized streams against a
// block-level model, on a default instance and a MAX_BLOCK=4 instance.
module tb_stored_block_packer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stored_block_packer_if b0 ();
   stored_block_packer_if b4 ();
   logic busy0, busy4;

`ifdef STORED_CRC32_EN
   logic [31:0] crc0, crc4;
   logic        crcv0, crcv4;
   stored_block_packer u_dut (.clk(clk), .rst(rst), .bus(b0), .busy(busy0),
                              .crc32_out(crc0), .crc32_valid(crcv0));
   stored_block_packer #(.MAX_BLOCK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4), .busy(busy4),
                                                .crc32_out(crc4), .crc32_valid(crcv4));
`else
   stored_block_packer u_dut (.clk(clk), .rst(rst), .bus(b0), .busy(busy0));
   stored_block_packer #(.MAX_BLOCK(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4), .busy(busy4));
`endif

   bit sel;  // 0: default instance, 1: MAX_BLOCK=4 instance
   wire        s_rd_en = sel ? b4.din_rd_en  : b0.din_rd_en;
   wire        s_valid = sel ? b4.dout_valid : b0.dout_valid;
   wire        s_last  = sel ? b4.dout_last  : b0.dout_last;
   wire [31:0] s_dout  = sel ? b4.dout_32    : b0.dout_32;
   wire [2:0]  s_bytes = sel ? b4.dout_bytes : b0.dout_bytes;
   wire        s_busy  = sel ? busy4 : busy0;
`ifdef STORED_CRC32_EN
   wire        s_crcv  = sel ? crcv4 : crcv0;
   wire [31:0] s_crc   = sel ? crc4  : crc0;
`endif

   logic [31:0] in_q[$];
   logic [7:0]  src[$];
   logic [7:0]  exp_bytes[$];
   logic [7:0]  out_bytes[$];
   logic [31:0] out_words[$];
   logic [31:0] exp_crc[$];
   logic [31:0] obs_crc[$];
   logic [31:0] model_crc;
   int          pops, exp_pops, last_cnt, exp_last_cnt, last_at, bad_bytes;
   logic [2:0]  last_nb;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic clear_run();
      in_q.delete(); src.delete(); exp_bytes.delete(); out_bytes.delete();
      out_words.delete(); exp_crc.delete(); obs_crc.delete();
      pops = 0; exp_pops = 0; last_cnt = 0; exp_last_cnt = 0; last_at = -1;
      bad_bytes = 0; last_nb = 3'd0; model_crc = 32'hFFFF_FFFF;
   endtask

   // Model: one input block -> input words + expected bytes, split into MAX_BLOCK segments.
   task automatic add_block(input bit bf, input int len, input bit rnd_flags);
      int rem, seg, mb;
      logic [7:0] b;
      logic [31:0] w;
      logic f;
      logic [6:0] junk;
      mb = sel ? 4 : 65535;
      junk = rnd_flags ? 7'($urandom) : 7'd0;
      in_q.push_back({len[7:0], len[15:8], len[23:16], junk, bf});
      exp_pops++;
      rem = len;
      do begin
         seg = (rem > mb) ? mb : rem;
         f = bf && (rem <= mb);
         exp_bytes.push_back({7'b0, f});
         exp_bytes.push_back(seg[7:0]);
         exp_bytes.push_back(seg[15:8]);
         exp_bytes.push_back(~seg[7:0]);
         exp_bytes.push_back(~seg[15:8]);
         for (int i = 0; i < seg; i += 4) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
               if (i + k < seg) begin
                  b = (src.size() != 0) ? src.pop_front() : 8'($urandom);
                  w[8*k +: 8] = b;
                  exp_bytes.push_back(b);
                  model_crc = crc_byte(model_crc, b);
               end
            end
            in_q.push_back(w);
            exp_pops++;
         end
         rem -= seg;
      end while (rem != 0);
      if (bf) begin
         exp_crc.push_back(~model_crc);
         model_crc = 32'hFFFF_FFFF;
         exp_last_cnt++;
      end
   endtask

   // One clock: called at a negedge, drives inputs, samples at +1, returns at the next negedge.
   task automatic tick(input bit rdy, input bit gap);
      logic [31:0] head;
      bit emp;
      head = (in_q.size() != 0) ? in_q[0] : 32'h0;
      emp  = gap || (in_q.size() == 0);
      b0.din_32 = sel ? 32'h0 : head;
      b0.din_empty = sel ? 1'b1 : emp;
      b4.din_32 = sel ? head : 32'h0;
      b4.din_empty = sel ? emp : 1'b1;
      b0.dout_ready = rdy;
      b4.dout_ready = rdy;
      #1;
      if (s_rd_en) begin
         pops++;
         if (in_q.size() != 0) void'(in_q.pop_front());
      end
      if (s_valid && rdy) begin
         out_words.push_back(s_dout);
         for (int k = 0; k < int'(s_bytes) && k < 4; k++) out_bytes.push_back(s_dout[8*k +: 8]);
         if (s_last) begin
            last_cnt++;
            last_at = out_bytes.size();
            last_nb = s_bytes;
         end else if (s_bytes != 3'd4) begin
            bad_bytes++;
         end
      end
`ifdef STORED_CRC32_EN
      if (s_crcv) obs_crc.push_back(s_crc);
`endif
      @(negedge clk);
   endtask

   task automatic run_stream(input bit rnd, output bit timed_out);
      int cyc;
      cyc = 0;
      timed_out = 1'b0;
      while (!((in_q.size() == 0) && !s_busy && !s_valid)) begin
         if (cyc >= 3000) begin
            timed_out = 1'b1;
            break;
         end
         tick(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, rnd && ($urandom_range(0, 4) == 0));
         cyc++;
      end
      tick(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sel = 1'b0;
      b0.din_32 = 32'h0100_0001; b0.din_empty = 1'b0; b0.dout_ready = 1'b1;
      b4.din_32 = 32'h0; b4.din_empty = 1'b1; b4.dout_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (b0.din_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL reset_rd_en: got %b expected 0", b0.din_rd_en);
      end
      n_checks++;
      if (b0.dout_32 !== 32'h0 || b0.dout_valid !== 1'b0 || b0.dout_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dout: got %h/%b/%b expected 0/0/0", b0.dout_32, b0.dout_valid,
                  b0.dout_last);
      end
      n_checks++;
      if (b0.dout_bytes !== 3'd4 || busy0 !== 1'b0) begin
         n_fail++; $display("FAIL reset_bytes_busy: got %0d/%b expected 4/0", b0.dout_bytes, busy0);
      end
`ifdef STORED_CRC32_EN
      n_checks++;
      if (crc0 !== 32'h0 || crcv0 !== 1'b0) begin
         n_fail++; $display("FAIL reset_crc: got %h/%b expected 0/0", crc0, crcv0);
      end
`endif
      b0.din_empty = 1'b1;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_streams();
      bit to;
      int nblk;
      for (int s = 0; s < 24; s++) begin
         clear_run();
         case (s)
            0: begin
               sel = 1'b0;
               for (int k = 0; k < 5; k++) src.push_back(8'h31 + 8'(k));
               src.push_back(8'h32);
               add_block(1'b1, 6, 1'b0);
            end
            1: begin sel = 1'b0; add_block(1'b1, 0, 1'b0); end
            2: begin
               sel = 1'b1;
               for (int k = 0; k < 6; k++) src.push_back(8'h61 + 8'(k));
               add_block(1'b1, 6, 1'b0);
            end
            3: begin
               sel = 1'b0;
               src.push_back(8'h61); src.push_back(8'h62);
               add_block(1'b0, 2, 1'b0);
               src.push_back(8'h63);
               add_block(1'b1, 1, 1'b0);
            end
            default: begin
               sel = 1'($urandom_range(0, 1));
               nblk = $urandom_range(1, 3);
               for (int j = 0; j < nblk; j++) begin
                  add_block(j == nblk - 1, $urandom_range(0, sel ? 14 : 20), 1'b1);
               end
            end
         endcase
         run_stream(s >= 4, to);
         n_checks++;
         if (to) begin n_fail++; $display("FAIL s%0d timeout: stream did not drain", s); end
         n_checks++;
         if (out_bytes.size() != exp_bytes.size()) begin
            n_fail++;
            $display("FAIL s%0d byte_count: got %0d expected %0d", s, out_bytes.size(),
                     exp_bytes.size());
         end
         for (int i = 0; i < out_bytes.size() && i < exp_bytes.size(); i++) begin
            n_checks++;
            if (out_bytes[i] !== exp_bytes[i]) begin
               n_fail++;
               $display("FAIL s%0d byte[%0d]: got %h expected %h", s, i, out_bytes[i],
                        exp_bytes[i]);
            end
         end
         n_checks++;
         if (pops != exp_pops) begin
            n_fail++; $display("FAIL s%0d pops: got %0d expected %0d", s, pops, exp_pops);
         end
         n_checks++;
         if (last_cnt != exp_last_cnt || last_at != exp_bytes.size()) begin
            n_fail++;
            $display("FAIL s%0d last: got count %0d at %0d expected count %0d at %0d", s,
                     last_cnt, last_at, exp_last_cnt, exp_bytes.size());
         end
         n_checks++;
         if (int'(last_nb) != ((exp_bytes.size() - 1) % 4) + 1 || bad_bytes != 0) begin
            n_fail++;
            $display("FAIL s%0d dout_bytes: got last %0d (%0d bad) expected %0d (0 bad)", s,
                     last_nb, bad_bytes, ((exp_bytes.size() - 1) % 4) + 1);
         end
`ifdef STORED_CRC32_EN
         n_checks++;
         if (obs_crc.size() != exp_crc.size()) begin
            n_fail++;
            $display("FAIL s%0d crc_pulses: got %0d expected %0d", s, obs_crc.size(),
                     exp_crc.size());
         end else begin
            for (int i = 0; i < exp_crc.size(); i++) begin
               n_checks++;
               if (obs_crc[i] !== exp_crc[i]) begin
                  n_fail++;
                  $display("FAIL s%0d crc: got %h expected %h", s, obs_crc[i], exp_crc[i]);
               end
            end
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int n;
      logic [31:0] exp_w[3];
      exp_w[0] = 32'hF900_0601; exp_w[1] = 32'h3332_31FF; exp_w[2] = 32'h0032_3534;
      clear_run();
      sel = 1'b0;
      in_q.push_back(32'h0600_0001);
      in_q.push_back(32'h3433_3231);
      in_q.push_back(32'h3433_3235);
      n = 0;
      while (!b0.dout_valid && n < 50) begin tick(1'b1, 1'b0); n++; end
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (b0.dout_valid !== 1'b1 || b0.dout_32 !== 32'hF900_0601) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got %b/%h expected 1/f9000601", c, b0.dout_valid,
                     b0.dout_32);
         end
         tick(1'b0, 1'b0);
      end
      n_checks++;
      if (pops != 1) begin n_fail++; $display("FAIL bp_pops_stalled: got %0d expected 1", pops); end
      run_stream(1'b0, to);
      n_checks++;
      if (to || out_words.size() != 3 || pops != 3) begin
         n_fail++;
         $display("FAIL bp_shape: got timeout %b words %0d pops %0d expected 0/3/3", to,
                  out_words.size(), pops);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_words[i] !== exp_w[i]) begin
               n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, out_words[i], exp_w[i]);
            end
         end
      end
      n_checks++;
      if (last_cnt != 1 || last_nb != 3'd3) begin
         n_fail++; $display("FAIL bp_last: got %0d/%0d expected 1/3", last_cnt, last_nb);
      end
   endtask

   task automatic test_mid_reset();
      bit to;
      clear_run();
      sel = 1'b0;
      for (int k = 0; k < 6; k++) src.push_back(8'h31 + 8'(k));
      add_block(1'b1, 6, 1'b0);
      repeat (7) tick(1'b1, 1'b0);
      b0.din_empty = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (b0.dout_valid !== 1'b0 || b0.dout_32 !== 32'h0 || b0.dout_last !== 1'b0 ||
          b0.dout_bytes !== 3'd4 || busy0 !== 1'b0 || b0.din_rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got v%b d%h l%b n%0d busy%b rd%b expected 0/0/0/4/0/0",
                  b0.dout_valid, b0.dout_32, b0.dout_last, b0.dout_bytes, busy0, b0.din_rd_en);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_run();
      add_block(1'b1, 0, 1'b0);
      run_stream(1'b0, to);
      n_checks++;
      if (to || out_words.size() != 2 || pops != 1) begin
         n_fail++;
         $display("FAIL midrst_shape: got timeout %b words %0d pops %0d expected 0/2/1", to,
                  out_words.size(), pops);
      end else begin
         n_checks++;
         if (out_words[0] !== 32'hFF00_0001 || out_words[1] !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL midrst_words: got %h %h expected ff000001 000000ff", out_words[0],
                     out_words[1]);
         end
      end
      n_checks++;
      if (last_cnt != 1 || last_nb != 3'd1) begin
         n_fail++; $display("FAIL midrst_last: got %0d/%0d expected 1/1", last_cnt, last_nb);
      end
   endtask

`ifdef STORED_CRC32_EN
   task automatic test_crc_check_value();
      bit to;
      clear_run();
      sel = 1'b0;
      for (int k = 0; k < 9; k++) src.push_back(8'h31 + 8'(k));
      add_block(1'b1, 9, 1'b0);
      run_stream(1'b0, to);
      n_checks++;
      if (to || obs_crc.size() != 1) begin
         n_fail++; $display("FAIL crc_pulse: got %0d pulses expected 1", obs_crc.size());
      end else if (obs_crc[0] !== 32'hCBF4_3926) begin
         n_fail++; $display("FAIL crc_check: got %h expected cbf43926", obs_crc[0]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_streams();
      test_backpressure();
      test_mid_reset();
`ifdef STORED_CRC32_EN
      test_crc_check_value();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
